mem_stage: RTL and testbench

Memory-access stage sitting between the execute stage and the byte-wide data RAM. It accepts the execute stage's memory request (enable/length/direction/sign code, effective address, store data), serialises it into one-byte RAM transactions, and assembles and sign- or zero-extends load data. It stalls upstream while busy and drives the registered write-back triple (address, enable, data) to the register-file write port. Non-memory results pass through with one register of latency.

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_load_ext.sv | 26 ++
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: request-code bit positions,
// length codes, the stage state enum and the length-to-last-byte helper.
package mem_stage_pkg;

    localparam int EN_BIT  = 4;
    localparam int LEN_MSB = 3;
    localparam int LEN_LSB = 2;
    localparam int WR_BIT  = 1;
    localparam int ZX_BIT  = 0;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Index of the final byte of an access; the reserved code 2 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] len);
        case (len)
            LEN_B:   return 2'd0;
            LEN_H:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data assembler: places the last received byte above the captured lanes
// and sign- or zero-extends the result according to the access length.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [1:0]  len,
    input  logic        zx,
    input  logic [23:0] lanes,
    input  logic [7:0]  last_byte,
    output logic [31:0] data
);

    logic fill;

    // The last byte always carries the sign bit of the access.
    always_comb begin
        fill = ~zx & last_byte[7];
        data = 32'd0;
        case (len)
            LEN_B:   data = {{24{fill}}, last_byte};
            LEN_H:   data = {{16{fill}}, last_byte, lanes[7:0]};
            default: data = {last_byte, lanes};
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: serialises requests into byte-wide RAM transactions and
// drives the registered write-back triple. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_mem_e,
    input  logic [31:0] res,
    input  logic [31:0] ex_mem_n,
    input  logic [4:0]  wa,
    input  logic        we,
    output logic [4:0]  wa_o,
    output logic        we_o,
    output logic [31:0] wn_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        zx_q, zx_d;
    logic [4:0]  wa_q, wa_d;
    logic        we_q, we_d;
    logic [23:0] lanes_q, lanes_d;
    logic [4:0]  wa_o_q, wa_o_d;
    logic        we_o_q, we_o_d;
    logic [31:0] wn_o_q, wn_o_d;
    logic        err_q, err_d;

    logic [1:0]  req_len;
    logic [31:0] load_data;
    logic        misaligned;

    assign req_len = ex_mem_e[LEN_MSB:LEN_LSB];

    mem_load_ext u_load_ext (
        .len       (len_q),
        .zx        (zx_q),
        .lanes     (lanes_q),
        .last_byte (ram_din),
        .data      (load_data)
    );

`ifdef MEM_ALIGN_CHECK_EN
    // Halves need an even address, words (including the reserved code) a multiple of four.
    always_comb begin
        case (req_len)
            LEN_B:   misaligned = 1'b0;
            LEN_H:   misaligned = res[0];
            default: misaligned = (res[1:0] != 2'd0);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and write-back logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        zx_d    = zx_q;
        wa_d    = wa_q;
        we_d    = we_q;
        lanes_d = lanes_q;
        wa_o_d  = wa_o_q;
        we_o_d  = we_o_q;
        wn_o_d  = wn_o_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_mem_e[EN_BIT]) begin
                    we_o_d = 1'b0;
                    if (misaligned) begin
                        wn_o_d = 32'd0;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ACC;
                        idx_d   = 2'd0;
                        len_d   = req_len;
                        addr_d  = res;
                        data_d  = ex_mem_n;
                        wr_d    = ex_mem_e[WR_BIT];
                        zx_d    = ex_mem_e[ZX_BIT];
                        wa_d    = wa;
                        we_d    = we;
                    end
                end else begin
                    wa_o_d = wa;
                    we_o_d = we;
                    wn_o_d = res;
                end
            end
            ACC: begin
                // Read data lags the address by one cycle, so lane i-1 arrives at index i.
                if (!wr_q) begin
                    case (idx_q)
                        2'd1:    lanes_d[7:0]   = ram_din;
                        2'd2:    lanes_d[15:8]  = ram_din;
                        2'd3:    lanes_d[23:16] = ram_din;
                        default: lanes_d = lanes_q;
                    endcase
                end
                if (idx_q == last_idx(len_q)) begin
                    if (wr_q) begin
                        state_d = IDLE;
                        we_o_d  = 1'b0;
                        wn_o_d  = 32'd0;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            WAIT: begin
                wn_o_d  = load_data;
                wa_o_d  = wa_q;
                we_o_d  = we_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port is only active while issuing bytes.
    always_comb begin
        ram_a    = 32'd0;
        ram_wr   = 1'b0;
        ram_dout = 8'd0;
        if (state_q == ACC) begin
            ram_a  = addr_q + {30'd0, idx_q};
            ram_wr = wr_q;
            if (wr_q) begin
                case (idx_q)
                    2'd0:    ram_dout = data_q[7:0];
                    2'd1:    ram_dout = data_q[15:8];
                    2'd2:    ram_dout = data_q[23:16];
                    default: ram_dout = data_q[31:24];
                endcase
            end else begin
                ram_dout = 8'd0;
            end
        end else begin
            ram_a = 32'd0;
        end
    end

    assign stall_o = (state_q != IDLE) | ex_mem_e[EN_BIT];
    assign wa_o    = wa_o_q;
    assign we_o    = we_o_q;
    assign wn_o    = wn_o_q;
    assign err_o   = err_q;

    // State and write-back registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            len_q   <= 2'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            zx_q    <= 1'b0;
            wa_q    <= 5'd0;
            we_q    <= 1'b0;
            lanes_q <= 24'd0;
            wa_o_q  <= 5'd0;
            we_o_q  <= 1'b0;
            wn_o_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            zx_q    <= zx_d;
            wa_q    <= wa_d;
            we_q    <= we_d;
            lanes_q <= lanes_d;
            wa_o_q  <= wa_o_d;
            we_o_q  <= we_o_d;
            wn_o_q  <= wn_o_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte-wide RAM model whose
// read data is valid one cycle after the address.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_mem_e;
    logic [31:0] res;
    logic [31:0] ex_mem_n;
    logic [4:0]  wa;
    logic        we;
    logic [4:0]  wa_o;
    logic        we_o;
    logic [31:0] wn_o;
    logic        stall_o;
    logic        err_o;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic [7:0]  mem [0:4095];
    logic [7:0]  rd_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk      (clk),
        .rst      (rst),
        .ex_mem_e (ex_mem_e),
        .res      (res),
        .ex_mem_n (ex_mem_n),
        .wa       (wa),
        .we       (we),
        .wa_o     (wa_o),
        .we_o     (we_o),
        .wn_o     (wn_o),
        .stall_o  (stall_o),
        .err_o    (err_o),
        .ram_a    (ram_a),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din)
    );

    always @(posedge clk) begin
        if (ram_wr) mem[ram_a[11:0]] <= ram_dout;
        rd_q <= mem[ram_a[11:0]];
    end
    assign ram_din = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_mem_e = 5'd0;
        res      = 32'd0;
        ex_mem_n = 32'd0;
        wa       = 5'd0;
        we       = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [4:0] code, input logic [31:0] addr,
                            input logic [31:0] data, input int n);
        int stalls;
        ex_mem_e = code;
        res      = addr;
        ex_mem_n = data;
        wa       = 5'd7;
        we       = 1'b1;
        #1;
        stalls = stall_o ? 1 : 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (k == 0) begin
                idle_inputs();
                check({tag, "/we_o"}, {31'd0, we_o}, 32'd0);
            end
            check({tag, "/ram_wr"}, {31'd0, ram_wr}, 32'd1);
            check({tag, "/ram_a"}, ram_a, addr + 32'(k));
            check({tag, "/ram_dout"}, {24'd0, ram_dout}, (data >> (8 * k)) & 32'h0000_00FF);
        end
        @(negedge clk);
        check({tag, "/stall_end"}, {31'd0, stall_o}, 32'd0);
        check({tag, "/ram_wr_end"}, {31'd0, ram_wr}, 32'd0);
        check({tag, "/we_o_end"}, {31'd0, we_o}, 32'd0);
        check({tag, "/stall_cycles"}, 32'(stalls), 32'(n + 1));
    endtask

    task automatic do_load(input string tag, input logic [4:0] code, input logic [31:0] addr,
                           input int n, input logic [31:0] exp, input logic [4:0] wa_in, input bit b2b);
        int stalls;
        ex_mem_e = code;
        res      = addr;
        ex_mem_n = 32'd0;
        wa       = wa_in;
        we       = 1'b1;
        #1;
        stalls = stall_o ? 1 : 0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (k == 0) begin
                idle_inputs();
                check({tag, "/we_o_busy"}, {31'd0, we_o}, 32'd0);
            end
            if (k == n && b2b) begin
                ex_mem_e = 5'd0;
                res      = 32'h0000_CAFE;
                wa       = 5'd9;
                we       = 1'b1;
            end
        end
        @(negedge clk);
        check({tag, "/wn_o"}, wn_o, exp);
        check({tag, "/we_o"}, {31'd0, we_o}, 32'd1);
        check({tag, "/wa_o"}, {27'd0, wa_o}, {27'd0, wa_in});
        check({tag, "/stall_cycles"}, 32'(stalls), 32'(n + 2));
        if (b2b) begin
            @(negedge clk);
            check({tag, "/b2b_wn_o"}, wn_o, 32'h0000_CAFE);
            check({tag, "/b2b_wa_o"}, {27'd0, wa_o}, 32'd9);
            check({tag, "/b2b_stall"}, {31'd0, stall_o}, 32'd0);
            idle_inputs();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst/wn_o", wn_o, 32'd0);
        check("rst/outs", {24'd0, wa_o, we_o, stall_o, err_o}, 32'd0);
        check("rst/ram", {23'd0, ram_wr, ram_dout} | ram_a, 32'd0);
        rst = 1'b0;

        // ALU pass-through
        res = 32'h0000_1234;
        wa  = 5'd5;
        we  = 1'b1;
        #1;
        check("alu/stall_now", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        check("alu/wn_o", wn_o, 32'h0000_1234);
        check("alu/wa_o", {27'd0, wa_o}, 32'd5);
        check("alu/we_o", {31'd0, we_o}, 32'd1);
        check("alu/stall", {31'd0, stall_o}, 32'd0);
        idle_inputs();
        @(negedge clk);

        // Stores: SW, SB, SH, SB
        do_store("sw", 5'h1E, 32'h0000_0100, 32'hDEAD_BEEF, 4);
        check("sw/mem", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEAD_BEEF);
        do_store("sb200", 5'h12, 32'h0000_0200, 32'h0000_0080, 1);
        do_store("sh2fe", 5'h16, 32'h0000_02FE, 32'h0000_9234, 2);
        do_store("sb300", 5'h12, 32'h0000_0300, 32'h0000_0055, 1);
        check("sh/mem", {16'd0, mem[12'h2FF], mem[12'h2FE]}, 32'h0000_9234);

        // Loads with sign/zero extension
        do_load("lb",  5'h10, 32'h0000_0200, 1, 32'hFFFF_FF80, 5'd3, 1'b0);
        do_load("lbu", 5'h11, 32'h0000_0200, 1, 32'h0000_0080, 5'd3, 1'b0);
        do_load("lh",  5'h14, 32'h0000_02FE, 2, 32'hFFFF_9234, 5'd4, 1'b0);
        do_load("lhu", 5'h15, 32'h0000_02FE, 2, 32'h0000_9234, 5'd4, 1'b0);
        do_load("lw_rsv", 5'h18, 32'h0000_0100, 4, 32'hDEAD_BEEF, 5'd8, 1'b1);

        // Misaligned half-word
`ifdef MEM_ALIGN_CHECK_EN
        ex_mem_e = 5'h14;
        res      = 32'h0000_02FF;
        wa       = 5'd2;
        we       = 1'b1;
        #1;
        check("mis/stall_accept", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mis/err", {31'd0, err_o}, 32'd1);
        check("mis/ram_wr", {31'd0, ram_wr}, 32'd0);
        check("mis/ram_a", ram_a, 32'd0);
        check("mis/we_o", {31'd0, we_o}, 32'd0);
        check("mis/stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        check("mis/err_end", {31'd0, err_o}, 32'd0);
`else
        do_load("lh_mis", 5'h14, 32'h0000_02FF, 2, 32'h0000_5592, 5'd2, 1'b0);
        check("mis/err", {31'd0, err_o}, 32'd0);
`endif

        // Reset in the middle of a store
        res = 32'h0000_A5A5;
        wa  = 5'd4;
        we  = 1'b1;
        @(negedge clk);
        ex_mem_e = 5'h1E;
        res      = 32'h0000_0100;
        ex_mem_n = 32'h1122_3344;
        @(negedge clk);
        idle_inputs();
        check("rstmid/ram_wr", {31'd0, ram_wr}, 32'd1);
        check("rstmid/ram_dout", {24'd0, ram_dout}, 32'h0000_0044);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid/wn_o", wn_o, 32'd0);
        check("rstmid/outs", {24'd0, wa_o, we_o, stall_o, err_o}, 32'd0);
        check("rstmid/ram", {23'd0, ram_wr, ram_dout} | ram_a, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid/stall", {31'd0, stall_o}, 32'd0);
        check("rstmid/mem", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEAD_BE44);
        do_load("lw_part", 5'h1C, 32'h0000_0100, 4, 32'hDEAD_BE44, 5'd6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
